mem_access_stage: RTL and testbench

- Memory (M) stage of the 64-bit in-order pipeline.
- Sits between the EX/M stage register and the M/WB stage register, and owns the word-addressed data memory.
- Passes ALU results through, performs stores, and runs multi-cycle loads, stalling upstream via stall_M.
- Outputs WRegEn_M, Dout_M and WReg1_M drive the M/WB register inputs directly.

---
 rtl/mem_access_stage.sv | 119 +++++++++++
 tb/tb_mem_access_stage.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/mem_access_stage.sv
// Memory stage of the 64-bit in-order pipeline: ALU pass-through, stores,
// and multi-cycle loads that hold the upstream stages via stall_M.
module mem_access_stage #(
  parameter int ADDR_W = 8,
  parameter int RD_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_X,
  input  logic        MemRead_X,
  input  logic        MemWrite_X,
  input  logic        WRegEn_X,
  input  logic [2:0]  WReg1_X,
  input  logic [63:0] ALU_X,
  input  logic [63:0] StData_X,
  output logic        WRegEn_M,
  output logic [63:0] Dout_M,
  output logic [2:0]  WReg1_M,
  output logic        stall_M
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [2:0] LAT_INIT = 3'(RD_LAT - 1);

  typedef enum logic {IDLE, LOAD_WAIT} state_t;

  state_t              r_state;
  state_t              w_nextState;
  logic [2:0]          r_lat;
  logic [ADDR_W-1:0]   r_addr;
  logic [2:0]          r_wReg1;
  logic                r_wRegEn;
  logic [63:0]         r_rdData;
  logic [63:0]         r_mem [DEPTH] = '{default: '0};

  logic [ADDR_W-1:0]   w_addr;
  logic                w_accept;
  logic                w_store;
  logic                w_unusedAluHigh;

  assign w_addr          = ALU_X[ADDR_W-1:0];
  assign w_unusedAluHigh = ^ALU_X[63:ADDR_W];
  assign w_accept        = (r_state == IDLE) && valid_X && MemRead_X;
  assign w_store         = (r_state == IDLE) && valid_X && MemWrite_X && !MemRead_X;

  // Storage is deliberately outside the reset domain; the load word is
  // sampled at the accept edge so a store one cycle earlier is visible.
  always_ff @(posedge clk) begin
    if (w_store) begin
      r_mem[w_addr] <= StData_X;
    end
    if (w_accept) begin
      r_rdData <= r_mem[w_addr];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_lat    <= '0;
      r_addr   <= '0;
      r_wReg1  <= '0;
      r_wRegEn <= 1'b0;
    end else begin
      r_state <= w_nextState;
      if (w_accept) begin
        r_lat    <= LAT_INIT;
        r_addr   <= w_addr;
        r_wReg1  <= WReg1_X;
        r_wRegEn <= WRegEn_X;
      end else if (r_state == LOAD_WAIT && r_lat != 3'd0) begin
        r_lat <= r_lat - 3'd1;
      end
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:      if (w_accept) w_nextState = LOAD_WAIT;
      LOAD_WAIT: if (r_lat == 3'd0) w_nextState = IDLE;
      default:   w_nextState = IDLE;
    endcase
  end

  // Stalled and store cycles present a clean bubble: enable, index and data all zero.
  always_comb begin
    WRegEn_M = 1'b0;
    Dout_M   = '0;
    WReg1_M  = '0;
    stall_M  = 1'b0;
    case (r_state)
      IDLE: begin
        if (valid_X) begin
          if (MemRead_X) begin
            stall_M = 1'b1;
          end else if (!MemWrite_X) begin
            WRegEn_M = WRegEn_X;
            Dout_M   = ALU_X;
            WReg1_M  = WReg1_X;
          end
        end
      end
      LOAD_WAIT: begin
        if (r_lat != 3'd0) begin
          stall_M = 1'b1;
        end else begin
          WRegEn_M = r_wRegEn;
          Dout_M   = r_rdData;
          WReg1_M  = r_wReg1;
        end
      end
      default: begin
        stall_M = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: three instances at read latencies 1, 2 and 4,
// driven by directed and random transactions against a word-array model.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        validX    [3];
  logic        memReadX  [3];
  logic        memWriteX [3];
  logic        wRegEnX   [3];
  logic [2:0]  wReg1X    [3];
  logic [63:0] aluX      [3];
  logic [63:0] stDataX   [3];
  wire         wRegEnM   [3];
  wire  [63:0] doutM     [3];
  wire  [2:0]  wReg1M    [3];
  wire         stallM    [3];

  logic [63:0] modelMem [3][256];
  int nChecks = 0;
  int nFails  = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : gLat
    mem_access_stage #(
      .ADDR_W(8),
      .RD_LAT((g == 0) ? 1 : ((g == 1) ? 2 : 4))
    ) uDut (
      .clk       (clk),
      .rst       (rst),
      .valid_X   (validX[g]),
      .MemRead_X (memReadX[g]),
      .MemWrite_X(memWriteX[g]),
      .WRegEn_X  (wRegEnX[g]),
      .WReg1_X   (wReg1X[g]),
      .ALU_X     (aluX[g]),
      .StData_X  (stDataX[g]),
      .WRegEn_M  (wRegEnM[g]),
      .Dout_M    (doutM[g]),
      .WReg1_M   (wReg1M[g]),
      .stall_M   (stallM[g])
    );
  end

  function automatic int latOf(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 2 : 4);
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic checkIdleOutputs(input int k, input string tag);
    checkOutput($sformatf("L%0d %s.wRegEn", latOf(k), tag), 64'(wRegEnM[k]), 64'd0);
    checkOutput($sformatf("L%0d %s.dout", latOf(k), tag), doutM[k], 64'd0);
    checkOutput($sformatf("L%0d %s.wReg1", latOf(k), tag), 64'(wReg1M[k]), 64'd0);
    checkOutput($sformatf("L%0d %s.stall", latOf(k), tag), 64'(stallM[k]), 64'd0);
  endtask

  // kind: 0 idle, 1 ALU op, 2 store, 3 load, 4 load with MemWrite also set
  task automatic applyStimulus(input int k, input int kind, input logic [63:0] alu,
                               input logic [63:0] st, input logic [2:0] dest, input logic en);
    logic [63:0] expData;
    logic [7:0]  a;
    string       p;
    a = alu[7:0];
    p = $sformatf("L%0d", latOf(k));
    @(negedge clk);
    validX[k]    = (kind != 0);
    memReadX[k]  = (kind >= 3);
    memWriteX[k] = (kind == 2 || kind == 4);
    wRegEnX[k]   = en;
    wReg1X[k]    = dest;
    aluX[k]      = alu;
    stDataX[k]   = st;
    #1;
    case (kind)
      0: checkIdleOutputs(k, "idle");
      1: begin
        checkOutput({p, " alu.wRegEn"}, 64'(wRegEnM[k]), 64'(en));
        checkOutput({p, " alu.dout"}, doutM[k], alu);
        checkOutput({p, " alu.wReg1"}, 64'(wReg1M[k]), 64'(dest));
        checkOutput({p, " alu.stall"}, 64'(stallM[k]), 64'd0);
      end
      2: begin
        checkIdleOutputs(k, "store");
        modelMem[k][a] = st;
      end
      default: begin
        expData = modelMem[k][a];
        for (int c = 0; c < latOf(k); c++) begin
          if (c > 0) begin
            @(negedge clk);
            #1;
          end
          checkOutput($sformatf("%s load.stall%0d", p, c), 64'(stallM[k]), 64'd1);
          checkOutput($sformatf("%s load.bubble%0d", p, c), 64'(wRegEnM[k]), 64'd0);
        end
        @(negedge clk);
        #1;
        checkOutput({p, " deliver.stall"}, 64'(stallM[k]), 64'd0);
        checkOutput({p, " deliver.wRegEn"}, 64'(wRegEnM[k]), 64'(en));
        checkOutput({p, " deliver.dout"}, doutM[k], expData);
        checkOutput({p, " deliver.wReg1"}, 64'(wReg1M[k]), 64'(dest));
        validX[k]   = 1'b0;
        memReadX[k] = 1'b0;
      end
    endcase
  endtask

  initial begin
    logic [63:0] alu;
    int          kind;
    for (int k = 0; k < 3; k++) begin
      validX[k] = 0; memReadX[k] = 0; memWriteX[k] = 0; wRegEnX[k] = 0;
      wReg1X[k] = 0; aluX[k] = 0; stDataX[k] = 0;
      for (int i = 0; i < 256; i++) modelMem[k][i] = '0;
    end

    repeat (2) @(negedge clk);
    #1;
    for (int k = 0; k < 3; k++) checkIdleOutputs(k, "reset");
    rst = 1'b0;

    applyStimulus(1, 1, 64'h1234, 64'h0, 3'd5, 1'b1);
    applyStimulus(1, 2, 64'd3, 64'hDEADBEEF_CAFEF00D, 3'd0, 1'b1);
    applyStimulus(1, 3, 64'd3, 64'h0, 3'd2, 1'b1);

    for (int k = 0; k < 3; k += 2) begin
      applyStimulus(k, 2, 64'd7, 64'h0707_0707_0707_0707, 3'd1, 1'b0);
      applyStimulus(k, 3, 64'd7, 64'h0, 3'd6, 1'b1);
    end

    applyStimulus(1, 2, 64'd1, 64'h11, 3'd0, 1'b0);
    applyStimulus(1, 2, 64'd2, 64'h22, 3'd0, 1'b0);
    applyStimulus(1, 3, 64'd1, 64'h0, 3'd3, 1'b1);
    applyStimulus(1, 3, 64'd2, 64'h0, 3'd4, 1'b1);
    applyStimulus(1, 0, 64'h0, 64'h0, 3'd0, 1'b0);

    applyStimulus(1, 2, 64'd4, 64'h44, 3'd0, 1'b0);
    applyStimulus(1, 4, 64'd4, 64'h99, 3'd7, 1'b1);
    applyStimulus(1, 3, 64'd4, 64'h0, 3'd7, 1'b1);

    // Reset in the first wait cycle abandons the load but keeps memory.
    applyStimulus(1, 2, 64'd9, 64'hABCD_0000_1234_5678, 3'd0, 1'b0);
    @(negedge clk);
    validX[1] = 1'b1; memReadX[1] = 1'b1; memWriteX[1] = 1'b0;
    wRegEnX[1] = 1'b1; wReg1X[1] = 3'd1; aluX[1] = 64'd9;
    #1;
    checkOutput("L2 rstLoad.accept", 64'(stallM[1]), 64'd1);
    @(negedge clk);
    #1;
    checkOutput("L2 rstLoad.wait", 64'(stallM[1]), 64'd1);
    rst = 1'b1;
    validX[1] = 1'b0; memReadX[1] = 1'b0;
    @(negedge clk);
    #1;
    checkIdleOutputs(1, "rstLoad.after");
    rst = 1'b0;
    applyStimulus(1, 3, 64'd9, 64'h0, 3'd1, 1'b1);

    applyStimulus(1, 2, 64'h100, 64'h0000_5555_AAAA_0000, 3'd0, 1'b0);
    applyStimulus(1, 3, 64'd0, 64'h0, 3'd2, 1'b1);

    for (int k = 0; k < 3; k++) begin
      for (int n = 0; n < 150; n++) begin
        kind = $urandom_range(0, 4);
        alu  = {$urandom, $urandom};
        if (kind >= 2) alu[7:4] = 4'h0;
        applyStimulus(k, kind, alu, {$urandom, $urandom}, 3'($urandom_range(0, 7)),
                      1'($urandom_range(0, 1)));
      end
      applyStimulus(k, 0, 64'h0, 64'h0, 3'd0, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
